// File: rtl/trap_sequencer.sv
// rtl/trap_sequencer.sv - M-mode timer-trap entry and MRET sequencer driving the CSR write port and fetch redirect
// Optional feature macro: TRAP_VECTORED_EN (vectored trap target when mtvec mode is 2'b01)
module trap_sequencer #(
    parameter int XLEN        = 32,
    parameter int CAUSE_TIMER = 7
) (
    input  logic            clk_in,
    input  logic            rst_in,
    input  logic            rdy_in,
    input  logic            commit_valid_in,
    input  logic [XLEN-1:0] commit_next_pc_in,
    input  logic            mret_in,
    input  logic            timer_irq_in,
    input  logic            mie_mtie_in,
    input  logic [XLEN-1:0] mstatus_in,
    input  logic [XLEN-1:0] mtvec_in,
    input  logic [XLEN-1:0] mepc_in,
    input  logic            csr_inst_we_in,
    output logic            csr_we_out,
    output logic [11:0]     csr_waddr_out,
    output logic [XLEN-1:0] csr_wdata_out,
    output logic            flush_out,
    output logic            trap_busy_out,
    output logic            redirect_valid_out,
    output logic [XLEN-1:0] redirect_pc_out
);

    localparam logic [11:0] ADDR_MSTATUS = 12'h300;
    localparam logic [11:0] ADDR_MEPC    = 12'h341;
    localparam logic [11:0] ADDR_MCAUSE  = 12'h342;

    localparam logic [XLEN-1:0] MCAUSE_VAL = {1'b1, (XLEN-1)'(CAUSE_TIMER)};

    typedef enum logic [2:0] {
        IDLE,
        WR_MEPC,
        WR_MCAUSE,
        WR_MSTATUS,
        MRET_STATUS,
        REDIRECT
    } state_t;

    state_t          state_q;
    state_t          state_d;
    logic [XLEN-1:0] epc_q;
    logic [XLEN-1:0] target_q;
    logic            first_q;
    logic            is_mret_q;

    logic            take_mret;
    logic            take_irq;
    logic            accept;
    logic            write_state;
    logic            write_go;
    logic [XLEN-1:0] trap_status;
    logic [XLEN-1:0] mret_status;
    logic [XLEN-1:0] trap_base;
    logic [XLEN-1:0] trap_target;

    // MRET wins over a simultaneous interrupt; the interrupt is re-evaluated after the return.
    assign take_mret = commit_valid_in & mret_in;
    assign take_irq  = commit_valid_in & ~mret_in & timer_irq_in & mie_mtie_in & mstatus_in[3];
    assign accept    = take_mret | take_irq;

    assign write_state = (state_q == WR_MEPC) || (state_q == WR_MCAUSE) ||
                         (state_q == WR_MSTATUS) || (state_q == MRET_STATUS);
    assign write_go    = write_state & rdy_in & ~csr_inst_we_in;

    always_comb begin
        trap_status        = mstatus_in;
        trap_status[7]     = mstatus_in[3];
        trap_status[3]     = 1'b0;
        trap_status[12:11] = 2'b11;
        mret_status        = mstatus_in;
        mret_status[3]     = mstatus_in[7];
        mret_status[7]     = 1'b1;
        mret_status[12:11] = 2'b11;
    end

    assign trap_base = {mtvec_in[XLEN-1:2], 2'b00};
`ifdef TRAP_VECTORED_EN
    assign trap_target = (mtvec_in[1:0] == 2'b01) ? trap_base + XLEN'(4 * CAUSE_TIMER) : trap_base;
`else
    logic mtvec_mode_unused;
    assign mtvec_mode_unused = ^mtvec_in[1:0];
    assign trap_target       = trap_base;
`endif

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state_q   <= IDLE;
            epc_q     <= '0;
            target_q  <= '0;
            first_q   <= 1'b0;
            is_mret_q <= 1'b0;
        end else if (rdy_in) begin
            state_q <= state_d;
            if (state_q == IDLE) begin
                first_q <= accept;
                if (take_mret) begin
                    target_q  <= mepc_in;
                    is_mret_q <= 1'b1;
                end else if (take_irq) begin
                    epc_q     <= commit_next_pc_in;
                    is_mret_q <= 1'b0;
                end
            end else begin
                first_q <= 1'b0;
            end
        end
    end

    always_comb begin
        state_d            = state_q;
        csr_waddr_out      = '0;
        csr_wdata_out      = '0;
        redirect_valid_out = 1'b0;
        redirect_pc_out    = '0;
        case (state_q)
            IDLE: begin
                if (take_mret) begin
                    state_d = MRET_STATUS;
                end else if (take_irq) begin
                    state_d = WR_MEPC;
                end
            end
            WR_MEPC: begin
                csr_waddr_out = ADDR_MEPC;
                csr_wdata_out = epc_q;
                if (write_go) state_d = WR_MCAUSE;
            end
            WR_MCAUSE: begin
                csr_waddr_out = ADDR_MCAUSE;
                csr_wdata_out = MCAUSE_VAL;
                if (write_go) state_d = WR_MSTATUS;
            end
            WR_MSTATUS: begin
                csr_waddr_out = ADDR_MSTATUS;
                csr_wdata_out = trap_status;
                if (write_go) state_d = REDIRECT;
            end
            MRET_STATUS: begin
                csr_waddr_out = ADDR_MSTATUS;
                csr_wdata_out = mret_status;
                if (write_go) state_d = REDIRECT;
            end
            REDIRECT: begin
                redirect_valid_out = rdy_in;
                redirect_pc_out    = rdy_in ? (is_mret_q ? target_q : trap_target) : '0;
                state_d            = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign csr_we_out    = write_go;
    assign flush_out     = first_q & rdy_in;
    assign trap_busy_out = (state_q != IDLE);

endmodule
